// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - core request/response and data-memory bus signals of the load-store unit
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - data-side load-store unit: bus lane mapping, load extension, optional watchdog
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_EN.
module riscv_lsu #(
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  riscv_lsu_if.slave bus,
  output logic       bus_err_o
`ifdef LSU_MISALIGN_EN
  ,
  output logic       misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             req_q, we_q, err_q, stall;
  logic [3:0]       be_q, be_d;
  logic [31:0]      addr_q, wd_q, rd_q, wd_d, load_fmt;
  logic [2:0]       size_q;
  logic [1:0]       off_q;
  logic [TO_W-1:0]  cnt_q;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic             misal, timeout;

  // Store lanes: bytes and halfwords are replicated so any lane the enables select carries the data.
  always_comb begin
    be_d = 4'b1111;
    wd_d = bus.core_wd_i;
    case (bus.core_size_i)
      3'd0, 3'd4: begin
        be_d = 4'b0001 << bus.core_addr_i[1:0];
        wd_d = {4{bus.core_wd_i[7:0]}};
      end
      3'd1, 3'd5: begin
        be_d = bus.core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{bus.core_wd_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_b = bus.mem_rd_i[{off_q, 3'b000} +: 8];
  assign lane_h = off_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];

  always_comb begin
    case (size_q)
      3'd0:    load_fmt = {{24{lane_b[7]}}, lane_b};
      3'd4:    load_fmt = {24'd0, lane_b};
      3'd1:    load_fmt = {{16{lane_h[15]}}, lane_h};
      3'd5:    load_fmt = {16'd0, lane_h};
      default: load_fmt = bus.mem_rd_i;
    endcase
  end

  // Fires on the last permitted BUSY cycle; a ready in that same cycle still wins.
  assign timeout = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_EN
  logic mis_q;

  always_comb begin
    case (bus.core_size_i)
      3'd0, 3'd4: misal = 1'b0;
      3'd1, 3'd5: misal = bus.core_addr_i[0];
      default:    misal = |bus.core_addr_i[1:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) mis_q <= 1'b0;
    else       mis_q <= (state_q == IDLE) && bus.core_req_i && misal;
  end

  assign misalign_o = mis_q;
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = bus.core_req_i;
        if (bus.core_req_i) state_d = misal ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.mem_ready_i || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.core_req_i) begin
            addr_q <= {bus.core_addr_i[31:2], 2'b00};
            we_q   <= bus.core_we_i;
            be_q   <= be_d;
            wd_q   <= wd_d;
            size_q <= bus.core_size_i;
            off_q  <= bus.core_addr_i[1:0];
            if (misal) rd_q  <= 32'd0;
            else       req_q <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.mem_ready_i) begin
            req_q <= 1'b0;
            if (!we_q) rd_q <= load_fmt;
          end else if (timeout) begin
            req_q <= 1'b0;
            rd_q  <= 32'd0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        DONE:    cnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.core_stall_o = stall;
  assign bus.core_rd_o    = rd_q;
  assign bus.mem_req_o    = req_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_be_o     = be_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wd_o     = wd_q;
  assign bus_err_o        = err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - randomized self-checking bench for riscv_lsu against a transaction-level model
module tb_riscv_lsu;
  localparam int TO = 4;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic bus_err_o;
`ifdef LSU_MISALIGN_EN
  logic misalign_o;
`endif

  riscv_lsu_if bus();

  riscv_lsu #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .bus_err_o (bus_err_o)
`ifdef LSU_MISALIGN_EN
    ,
    .misalign_o(misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          stall, req, err, mis, fld, we;
    logic [3:0]  be;
    logic [31:0] addr, wd, rd;
  } exp_t;

  exp_t        q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int m_nb(logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int m_start(logic [2:0] sz, logic [31:0] a);
    int s;
    s = int'(a[1:0]);
    return s - (s % m_nb(sz));
  endfunction

  function automatic bit m_mis(logic [2:0] sz, logic [31:0] a);
    return MIS_EN && ((int'(a[1:0]) % m_nb(sz)) != 0);
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] sz, logic [31:0] a);
    return 4'(((1 << m_nb(sz)) - 1) << m_start(sz, a));
  endfunction

  function automatic logic [31:0] m_wd(logic [2:0] sz, logic [31:0] d);
    logic [31:0] r;
    int n;
    n = m_nb(sz);
    r = 32'd0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(logic [2:0] sz, logic [31:0] a, logic [31:0] w);
    logic [31:0] v, mask;
    int n;
    n    = m_nb(sz);
    v    = w >> (8 * m_start(sz, a));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = v & mask;
    if ((sz == 3'd0 || sz == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic exp_t mk(bit stall, bit req, bit err, logic [31:0] rd);
    exp_t r;
    r.stall = stall; r.req = req; r.err = err; r.rd = rd; r.mis = 1'b0;
    r.fld = 1'b0; r.we = 1'b0; r.be = 4'd0; r.addr = 32'd0; r.wd = 32'd0;
    return r;
  endfunction

  task automatic drive(input bit req, input bit we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy, input logic [31:0] rd);
    bus.core_req_i  = req;
    bus.core_we_i   = we;
    bus.core_size_i = sz;
    bus.core_addr_i = a;
    bus.core_wd_i   = d;
    bus.mem_ready_i = rdy;
    bus.mem_rd_i    = rd;
  endtask

  task automatic drive_noise(input bit req, input bit rdy, input logic [31:0] rd);
    drive(req, 1'($urandom), 3'($urandom), $urandom, $urandom, rdy, rd);
  endtask

  task automatic idle();
    @(posedge clk_i); #1;
    drive_noise(1'b0, 1'($urandom), $urandom);
    q.push_back(mk(1'b0, 1'b0, 1'b0, last_rd));
  endtask

  // w = BUSY cycles without ready before the ready cycle; w >= TO means ready never comes.
  task automatic access(input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input int w, input logic [31:0] rdw);
    exp_t e;
    int   busy;
    bit   tmo, rdy;
    tmo  = (w >= TO);
    busy = tmo ? TO : w + 1;
    @(posedge clk_i); #1;
    drive(1'b1, we, sz, a, d, 1'($urandom), $urandom);
    q.push_back(mk(1'b1, 1'b0, 1'b0, last_rd));
    if (m_mis(sz, a)) begin
      @(posedge clk_i); #1;
      drive_noise(1'($urandom), 1'($urandom), $urandom);
      last_rd = 32'd0;
      e = mk(1'b0, 1'b0, 1'b0, 32'd0);
      e.mis = 1'b1;
      q.push_back(e);
      return;
    end
    for (int i = 0; i < busy; i++) begin
      rdy = !tmo && (i == busy - 1);
      @(posedge clk_i); #1;
      drive_noise(1'($urandom), rdy, rdy ? rdw : $urandom);
      e = mk(1'b1, 1'b1, 1'b0, last_rd);
      e.fld = 1'b1; e.we = we; e.be = m_be(sz, a); e.addr = a & ~32'd3; e.wd = m_wd(sz, d);
      q.push_back(e);
    end
    if (tmo)      last_rd = 32'd0;
    else if (!we) last_rd = m_rd(sz, a, rdw);
    @(posedge clk_i); #1;
    drive_noise(1'($urandom), 1'($urandom), $urandom);
    q.push_back(mk(1'b0, 1'b0, tmo, last_rd));
  endtask

  task automatic reset_mid();
    exp_t e;
    @(posedge clk_i); #1;
    drive(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, 1'b0, $urandom);
    q.push_back(mk(1'b1, 1'b0, 1'b0, last_rd));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      if (i == 1) rst_i = 1'b1;
      drive_noise(1'b1, 1'b0, $urandom);
      e = mk(1'b1, 1'b1, 1'b0, last_rd);
      e.fld = 1'b1; e.be = 4'hF; e.addr = 32'h300;
      q.push_back(e);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive_noise(1'b0, 1'($urandom), $urandom);
    last_rd = 32'd0;
    e = mk(1'b0, 1'b0, 1'b0, 32'd0);
    e.fld = 1'b1;
    q.push_back(e);
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall", 32'(bus.core_stall_o), 32'(e.stall));
        chk("mem_req", 32'(bus.mem_req_o), 32'(e.req));
        chk("bus_err", 32'(bus_err_o), 32'(e.err));
        chk("core_rd", bus.core_rd_o, e.rd);
`ifdef LSU_MISALIGN_EN
        chk("misalign", 32'(misalign_o), 32'(e.mis));
`endif
        if (e.fld) begin
          chk("mem_we", 32'(bus.mem_we_o), 32'(e.we));
          chk("mem_be", 32'(bus.mem_be_o), 32'(e.be));
          chk("mem_addr", bus.mem_addr_o, e.addr);
          chk("mem_wd", bus.mem_wd_o, e.wd);
        end
      end
    end
  end

  initial begin : stim
    exp_t e;
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    e = mk(1'b0, 1'b0, 1'b0, 32'd0);
    e.fld = 1'b1;
    q.push_back(e);
    @(negedge clk_i);
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_core_rd", bus.core_rd_o, 32'd0);
    chk("rst_be", 32'(bus.mem_be_o), 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);

    access(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 1, $urandom);
    idle(); @(negedge clk_i);
    chk("sw_addr", bus.mem_addr_o, 32'h104);
    chk("sw_be", 32'(bus.mem_be_o), 32'hF);
    chk("sw_wd", bus.mem_wd_o, 32'hDEAD_BEEF);

    access(1'b1, 3'd0, 32'h203, 32'h0000_00A5, 0, $urandom);
    idle(); @(negedge clk_i);
    chk("sb_addr", bus.mem_addr_o, 32'h200);
    chk("sb_be", 32'(bus.mem_be_o), 32'h8);
    chk("sb_wd", bus.mem_wd_o, 32'hA5A5_A5A5);

    access(1'b0, 3'd0, 32'h2, 32'd0, 0, 32'h12F0_5678);
    idle(); @(negedge clk_i);
    chk("lb_rd", bus.core_rd_o, 32'hFFFF_FFF0);
    access(1'b0, 3'd4, 32'h2, 32'd0, 2, 32'h12F0_5678);
    idle(); @(negedge clk_i);
    chk("lbu_rd", bus.core_rd_o, 32'h0000_00F0);
    access(1'b0, 3'd1, 32'h2, 32'd0, 1, 32'h12F0_5678);
    idle(); @(negedge clk_i);
    chk("lh_rd", bus.core_rd_o, 32'h0000_12F0);

    access(1'b0, 3'd2, 32'h40, 32'd0, 9, $urandom);
    @(negedge clk_i);
    chk("tmo_err_pulse", 32'(bus_err_o), 32'd1);
    idle(); @(negedge clk_i);
    chk("tmo_err_clear", 32'(bus_err_o), 32'd0);
    chk("tmo_rd", bus.core_rd_o, 32'd0);
    access(1'b0, 3'd2, 32'h44, 32'd0, 3, 32'hCAFE_F00D);
    idle(); @(negedge clk_i);
    chk("after_tmo_rd", bus.core_rd_o, 32'hCAFE_F00D);

    reset_mid();
    @(negedge clk_i);
    chk("rst_mid_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_mid_rd", bus.core_rd_o, 32'd0);

`ifdef LSU_MISALIGN_EN
    access(1'b0, 3'd2, 32'h101, 32'd0, 0, $urandom);
    @(negedge clk_i);
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    chk("mis_req", 32'(bus.mem_req_o), 32'd0);
    chk("mis_rd", bus.core_rd_o, 32'd0);
`endif

    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 2)) idle();
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom_range(0, 6), $urandom);
    end
    repeat (3) idle();
    repeat (2) @(negedge clk_i);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
